// File: rtl/axi_lite_arb_pkg.sv
// rtl/axi_lite_arb_pkg.sv - shared state encoding, default widths and width helpers for the request arbiter
package axi_lite_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Register width able to hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority select starting after the last owner
module rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = clog2_min1(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  // Walk last+1, last+2, ... (mod NUM_REQ) and take the first pending request.
  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// rtl/axi_lite_req_arbiter.sv - round-robin sharing of one AXI4-Lite command port among NUM_REQ requesters
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int  NUM_REQ     = DEF_NUM_REQ,
  parameter int  ADDR_W      = DEF_ADDR_W,
  parameter int  DATA_W      = DEF_DATA_W,
  parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDW         = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      start_write,
  output logic                      start_read,
  output logic [ADDR_W-1:0]         write_address_M,
  output logic [DATA_W-1:0]         write_data,
  output logic [ADDR_W-1:0]         read_address,
  input  logic                      write_done,
  input  logic                      read_done,
  input  logic [DATA_W-1:0]         read_data
);

  localparam int             TW        = clog2_min1(TIMEOUT_CYC + 1);
  localparam int             TO_LAST   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [TW-1:0]  TO_LAST_V = TW'(TO_LAST);
  localparam logic [TW-1:0]  TIMER_MAX = '1;

  arb_state_t           state;
  logic [IDW-1:0]       last;
  logic                 write_done_q;
  logic                 read_done_q;
  logic                 cmd_write;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [DATA_W-1:0]    cmd_wdata;
  logic [TW-1:0]        timer;

  logic [NUM_REQ-1:0]   rr_grant;
  logic [IDW-1:0]       rr_idx;
  logic                 rr_any;
  logic                 wd_ev;
  logic                 rd_ev;
  logic                 done_ev;
  logic                 timeout_hit;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req       (req_valid),
    .last      (last),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // Only a rising edge counts, so a done level left over from the previous transaction is ignored.
  assign wd_ev       = write_done & ~write_done_q;
  assign rd_ev       = read_done & ~read_done_q;
  assign done_ev     = cmd_write ? wd_ev : rd_ev;
  assign timeout_hit = (TIMEOUT_CYC > 0) && (timer == TO_LAST_V);

  assign req_ready       = (state == ST_IDLE) ? rr_grant : '0;
  assign sel_addr        = req_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata       = req_wdata[int'(rr_idx)*DATA_W +: DATA_W];
  assign write_address_M = cmd_addr;
  assign read_address    = cmd_addr;
  assign write_data      = cmd_wdata;

  // Previous done levels for edge detection.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      write_done_q <= 1'b0;
      read_done_q  <= 1'b0;
    end else begin
      write_done_q <= write_done;
      read_done_q  <= read_done;
    end
  end

  // Transaction sequencer: grant, issue one start pulse, wait for done or timeout, respond.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_IDLE;
      last        <= IDW'(NUM_REQ - 1);
      grant_id    <= '0;
      cmd_write   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      timer       <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_write <= 1'b0;
      start_read  <= 1'b0;
      rsp_valid   <= '0;
      case (state)
        ST_IDLE: begin
          if (rr_any) begin
            cmd_write   <= req_write[rr_idx];
            cmd_addr    <= sel_addr;
            cmd_wdata   <= sel_wdata;
            grant_id    <= rr_idx;
            start_write <= req_write[rr_idx];
            start_read  <= ~req_write[rr_idx];
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_ev) begin
            rsp_rdata <= cmd_write ? '0 : read_data;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            state     <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            state     <= ST_RESP;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          last  <= grant_id;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// tb/tb_axi_lite_req_arbiter.sv - directed and randomized check of axi_lite_req_arbiter against a transaction model
module tb_axi_lite_req_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic [IDW-1:0]  grant_id;
  logic            start_write;
  logic            start_read;
  logic [AW-1:0]   write_address_M;
  logic [DW-1:0]   write_data;
  logic [AW-1:0]   read_address;
  logic            write_done = 1'b0;
  logic            read_done = 1'b0;
  logic [DW-1:0]   read_data = '0;

  axi_lite_req_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .start_write(start_write), .start_read(start_read),
    .write_address_M(write_address_M), .write_data(write_data), .read_address(read_address),
    .write_done(write_done), .read_done(read_done), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // ---------------- transaction-level reference model ----------------
  // phase: 0 free, 1 start cycle, 2 waiting for completion, 3 response cycle
  int            m_ph, m_owner, m_last, m_waited;
  logic          m_wr, m_err, m_wdq, m_rdq;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge clk or negedge arst_n) begin : model_step
    logic ev;
    int   w;
    if (!arst_n) begin
      m_ph = 0; m_owner = 0; m_last = N - 1; m_waited = 0;
      m_wr = 1'b0; m_err = 1'b0; m_wdq = 1'b0; m_rdq = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      ev = m_wr ? (write_done && !m_wdq) : (read_done && !m_rdq);
      case (m_ph)
        0: begin
          w = rr_pick(req_valid, m_last);
          if (w >= 0) begin
            m_owner = w;
            m_wr    = req_write[w];
            m_addr  = req_addr[w*AW +: AW];
            m_wdata = req_wdata[w*DW +: DW];
            m_ph    = 1;
          end
        end
        1: begin m_ph = 2; m_waited = 0; end
        2: begin
          m_waited++;
          if (ev) begin
            m_rdata = m_wr ? '0 : read_data;
            m_err = 1'b0; m_ph = 3;
          end else if (TO > 0 && m_waited == TO) begin
            m_rdata = '0; m_err = 1'b1; m_ph = 3;
          end
        end
        default: begin m_last = m_owner; m_ph = 0; end
      endcase
      m_wdq = write_done;
      m_rdq = read_done;
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int            cyc = 0, n_starts = 0, n_rsp = 0, start_t = 0, rsp_t = 0;
  int            start_gid[$];
  logic [AW-1:0] st_addr = '0;
  logic [N-1:0]  last_rsp = '0, ready_at_neg = '0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  always @(negedge clk) begin : compare
    logic [N-1:0] e_ready;
    int w;
    e_ready = '0;
    if (m_ph == 0) begin
      w = rr_pick(req_valid, m_last);
      if (w >= 0) e_ready[w] = 1'b1;
    end
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, m_ph != 0);
    chk("start_write", start_write, m_ph == 1 && m_wr);
    chk("start_read", start_read, m_ph == 1 && !m_wr);
    chk("grant_id", grant_id, m_owner);
    chk("write_address_M", write_address_M, m_addr);
    chk("read_address", read_address, m_addr);
    chk("write_data", write_data, m_wdata);
    chk("rsp_valid", rsp_valid, (m_ph == 3) ? (1 << m_owner) : 0);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    if (m_ph == 3 || !arst_n) chk("rsp_err", rsp_err, m_err);
    ready_at_neg = req_ready;
    if (start_write || start_read) begin
      n_starts++;
      start_gid.push_back(int'(grant_id));
      start_t = cyc;
      st_addr = start_write ? write_address_M : read_address;
    end
    if (rsp_valid != '0) begin
      n_rsp++;
      last_rsp = rsp_valid; last_rdata = rsp_rdata; last_err = rsp_err; rsp_t = cyc;
    end
    cyc++;
  end

  // ---------------- master model ----------------
  int            mcnt = -1, cfg_delay = 3;
  bit            cfg_noresp = 0, cfg_level = 0, cfg_rand = 0;
  logic          mst_wr = 1'b0;
  logic [AW-1:0] mst_addr = '0;
  logic [DW-1:0] mst_wdata = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  always begin : master
    @(posedge clk);
    #1;
    if (!arst_n) begin
      mcnt = -1; write_done = 1'b0; read_done = 1'b0;
    end else begin
      if (!cfg_level) begin write_done = 1'b0; read_done = 1'b0; end
      read_data = $urandom;
      if (start_write || start_read) begin
        mst_wr = start_write;
        mst_addr = write_address_M;
        mst_wdata = write_data;
        if (cfg_rand) begin
          cfg_level  = ($urandom_range(0, 1) == 1);
          cfg_noresp = ($urandom_range(0, 9) == 0);
          cfg_delay  = $urandom_range(2, 7);
        end
        mcnt = cfg_noresp ? -1 : cfg_delay;
      end else if (mcnt > 0) begin
        mcnt--;
        if (cfg_level && mcnt == 1) begin
          if (mst_wr) write_done = 1'b0; else read_done = 1'b0;
        end
        if (mcnt == 0) begin
          if (mst_wr) begin
            write_done = 1'b1; mem[mst_addr] = mst_wdata;
          end else begin
            read_done = 1'b1;
            read_data = mem.exists(mst_addr) ? mem[mst_addr] : ~mst_addr;
          end
          mcnt = -1;
        end else if (cfg_rand && !cfg_level && $urandom_range(0, 7) == 0) begin
          if (mst_wr) read_done = 1'b1; else write_done = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Present one request, withdraw it once accepted, return after its response or a cycle budget.
  task automatic run_txn(input string tag, input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int base;
    base = n_rsp;
    set_req(i, w, a, d);
    for (int k = 0; k < 60 && n_rsp == base; k++) begin
      cycle();
      if (ready_at_neg[i]) req_valid[i] = 1'b0;
    end
    req_valid[i] = 1'b0;
    chk({tag, " response seen"}, n_rsp - base, 1);
  endtask

  task automatic wait_rsps(input string tag, input int cnt, input bit drop_on_accept);
    int base;
    base = n_rsp;
    for (int k = 0; k < 200 && n_rsp - base < cnt; k++) begin
      cycle();
      if (drop_on_accept) req_valid = req_valid & ~ready_at_neg;
    end
    req_valid = '0;
    chk({tag, " responses seen"}, n_rsp - base, cnt);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bs;
    repeat (3) cycle();
    chk("reset busy", busy, 0);
    chk("reset start_write", start_write, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset grant_id", grant_id, 0);
    arst_n = 1'b1;
    cycle();

    // single write, done three cycles after the start pulse
    bs = n_starts;
    run_txn("t2", 0, 1'b1, 32'h10, 32'hA5A5A5A5);
    chk("t2 start count", n_starts - bs, 1);
    chk("t2 address", st_addr, 32'h10);
    chk("t2 owner", last_rsp, 3'b001);
    chk("t2 err", last_err, 0);
    chk("t2 rdata", last_rdata, 0);
    chk("t2 latency", rsp_t - start_t, 4);

    // read back through requester 1
    bs = n_starts;
    run_txn("t3", 1, 1'b0, 32'h10, 32'h0);
    chk("t3 start count", n_starts - bs, 1);
    chk("t3 owner", last_rsp, 3'b010);
    chk("t3 rdata", last_rdata, 32'hA5A5A5A5);
    chk("t3 err", last_err, 0);

    // two requesters held valid: grants alternate
    start_gid.delete();
    bs = n_starts;
    set_req(0, 1'b1, 32'h20, 32'h11111111);
    set_req(1, 1'b0, 32'h10, 32'h0);
    wait_rsps("t4", 4, 1'b0);
    chk("t4 start count", n_starts - bs, 4);
    chk("t4 grant 0", start_gid[0], 0);
    chk("t4 grant 1", start_gid[1], 1);
    chk("t4 grant 2", start_gid[2], 0);
    chk("t4 grant 3", start_gid[3], 1);

    // write_done left high: the next write must wait for a fresh rising edge
    cfg_level = 1;
    run_txn("t5a", 0, 1'b1, 32'h30, 32'h12345678);
    cfg_delay = 5;
    run_txn("t5b", 1, 1'b1, 32'h34, 32'h9ABCDEF0);
    chk("t5 owner", last_rsp, 3'b010);
    chk("t5 latency", rsp_t - start_t, 6);

    // read without completion: timeout after TO waiting cycles
    cfg_level = 0;
    cfg_noresp = 1;
    run_txn("t6a", 0, 1'b0, 32'h10, 32'h0);
    chk("t6 owner", last_rsp, 3'b001);
    chk("t6 err", last_err, 1);
    chk("t6 rdata", last_rdata, 0);
    chk("t6 latency", rsp_t - start_t, TO + 1);
    cfg_noresp = 0;
    cfg_delay = 2;
    run_txn("t6b", 1, 1'b1, 32'h40, 32'hCAFEF00D);
    chk("t6b owner", last_rsp, 3'b010);
    chk("t6b err", last_err, 0);

    // reset in the middle of WAIT
    cfg_noresp = 1;
    bs = n_starts;
    set_req(0, 1'b1, 32'h44, 32'h55AA55AA);
    for (int k = 0; k < 20 && n_starts == bs; k++) cycle();
    req_valid = '0;
    repeat (3) cycle();
    bs = n_rsp;
    #2;
    arst_n = 1'b0;
    #1;
    chk("t7 busy", busy, 0);
    chk("t7 start_write", start_write, 0);
    chk("t7 write_address_M", write_address_M, 0);
    chk("t7 rsp_valid", rsp_valid, 0);
    chk("t7 grant_id", grant_id, 0);
    repeat (2) cycle();
    arst_n = 1'b1;
    cfg_noresp = 0;
    cfg_delay = 2;
    start_gid.delete();
    set_req(2, 1'b1, 32'h48, 32'h1);
    set_req(1, 1'b0, 32'h44, 32'h0);
    set_req(0, 1'b0, 32'h10, 32'h0);
    wait_rsps("t7", 3, 1'b1);
    chk("t7 grant after reset", start_gid[0], 0);
    chk("t7 second grant", start_gid[1], 1);
    chk("t7 third grant", start_gid[2], 2);

    // randomized traffic
    cfg_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (ready_at_neg[i] || !req_valid[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 1) == 1)
            set_req(i, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15) * 4), $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    cfg_rand = 0;
    for (int k = 0; k < 40 && busy; k++) cycle();
    chk("final idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
